// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   SYNC_TAG      upper nibble(s) of the header word; low nibble carries the channel id
//   state_t       scheduler FSM states
//   guard_cycles  clocks to wait after reset so an in-flight uart_tx word can drain
package uart_tx_scheduler_pkg;

   localparam logic [7:0] SYNC_TAG = 8'hA0;

   typedef enum logic [1:0] {
      ST_GUARD = 2'd0,
      ST_IDLE  = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   // One full word (start + data + stop) plus one spare bit time, in clocks.
   function automatic int guard_cycles(input int word_width, input int stop_bits, input int shift);
      return (word_width + stop_bits + 2) << shift;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo N_CH.
//   req    in   N_CH  request vector
//   ptr    in   ID_W  highest-priority channel this round
//   grant  out  N_CH  one-hot grant (zero when no request)
//   idx    out  ID_W  index of the granted channel
//   any    out  1     at least one request present
module uart_tx_scheduler_rr_arbiter
   import uart_tx_scheduler_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic [N_CH-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [N_CH-1:0] grant,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   logic [ID_W-1:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 0; i < N_CH; i++) begin
         cand = ID_W'((int'(ptr) + i) % N_CH);
         if (!any && req[cand]) begin
            any         = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx serializer between N_CH frame requesters.
// Each granted frame goes out as an optional header word {SYNC_TAG, ch_id}
// followed by FRAME_WORDS data words, word 0 first.
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   req         in   per-channel frame request (level)
//   req_data    in   frames, channel c at [c*FRAME_WORDS*WORD_WIDTH +: FRAME_WORDS*WORD_WIDTH]
//   ack         out  one-clock pulse when a channel's frame is fully sent
//   busy        out  high in any state other than IDLE
//   grant_id    out  channel currently being sent
//   uart_din    out  word to uart_tx
//   uart_start  out  uart_tx tx_start
//   uart_done   in   uart_tx tx_done
//
// state    | meaning
// ST_GUARD | after reset: uart_start held low while uart_tx drains any old word
// ST_IDLE  | waiting for a request; grants on the next edge
// ST_SEND  | frame latched; advance one word per rising edge of uart_done
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int WORD_WIDTH  = 8,
   parameter int FRAME_WORDS = 4,
   parameter int HEADER      = 1,
   parameter int SHIFT       = 1,
   parameter int STOP_BITS   = 1,
   localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_CH-1:0]                   req,
   input  logic [N_CH*FRAME_WORDS*WORD_WIDTH-1:0] req_data,
   output logic [N_CH-1:0]                   ack,
   output logic                              busy,
   output logic [ID_W-1:0]                   grant_id,
   output logic [WORD_WIDTH-1:0]             uart_din,
   output logic                              uart_start,
   input  logic                              uart_done
);

   localparam int FRAME_W   = FRAME_WORDS * WORD_WIDTH;
   localparam int N_WORDS   = FRAME_WORDS + HEADER;
   localparam int CNT_W     = $clog2(N_WORDS + 1);
   localparam int GUARD_CYC = guard_cycles(WORD_WIDTH, STOP_BITS, SHIFT);
   localparam int GCNT_W    = $clog2(GUARD_CYC + 1);
   localparam logic [WORD_WIDTH-1:0] SYNC_W = WORD_WIDTH'(SYNC_TAG);

   state_t              state, state_n;
   logic [GCNT_W-1:0]   gcnt, gcnt_n;
   logic [CNT_W-1:0]    word_idx, word_n;
   logic [FRAME_W-1:0]  frame_q, frame_n;
   logic [ID_W-1:0]     grant_q, grant_n;
   logic [N_CH-1:0]     goh_q, goh_n;
   logic [ID_W-1:0]     ptr, ptr_n;
   logic [WORD_WIDTH-1:0] din_q, din_n;
   logic                start_q, start_n;
   logic [N_CH-1:0]     ack_q, ack_n;
   logic                done_q;

   logic [N_CH-1:0]     arb_grant;
   logic [ID_W-1:0]     arb_idx;
   logic                arb_any;
   logic [FRAME_W-1:0]  frame_in;
   logic                done_rise;
   logic                last;

   uart_tx_scheduler_rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   function automatic logic [WORD_WIDTH-1:0] word_of(input logic [CNT_W-1:0]   k,
                                                     input logic [FRAME_W-1:0] f,
                                                     input logic [ID_W-1:0]    g);
      logic [WORD_WIDTH-1:0] w;
      if (HEADER != 0 && k == '0)
         w = {SYNC_W[WORD_WIDTH-1:4], 4'(g)};
      else
         w = f[(int'(k) - HEADER) * WORD_WIDTH +: WORD_WIDTH];
      return w;
   endfunction

   assign frame_in  = req_data[int'(arb_idx) * FRAME_W +: FRAME_W];
   assign done_rise = uart_done & ~done_q;
   assign last      = (word_idx == CNT_W'(N_WORDS - 1));

   always_comb begin
      state_n = state;
      gcnt_n  = gcnt;
      word_n  = word_idx;
      frame_n = frame_q;
      grant_n = grant_q;
      goh_n   = goh_q;
      ptr_n   = ptr;
      din_n   = din_q;
      start_n = start_q;
      ack_n   = '0;
      case (state)
         ST_GUARD: begin
            start_n = 1'b0;
            if (gcnt == '0)
               state_n = ST_IDLE;
            else
               gcnt_n = gcnt - 1'b1;
         end
         ST_IDLE: begin
            if (arb_any) begin
               state_n = ST_SEND;
               grant_n = arb_idx;
               goh_n   = arb_grant;
               frame_n = frame_in;
               word_n  = '0;
               din_n   = word_of('0, frame_in, arb_idx);
               start_n = 1'b1;
            end
         end
         ST_SEND: begin
            // uart_start stays high between words so uart_tx picks up the
            // next word the moment it returns to idle.
            if (done_rise) begin
               if (last) begin
                  start_n = 1'b0;
                  ack_n   = goh_q;
                  ptr_n   = (grant_q == ID_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  word_n = word_idx + 1'b1;
                  din_n  = word_of(word_idx + 1'b1, frame_q, grant_q);
               end
            end
         end
         default: state_n = ST_GUARD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_GUARD;
         gcnt     <= GCNT_W'(GUARD_CYC - 1);
         word_idx <= '0;
         frame_q  <= '0;
         grant_q  <= '0;
         goh_q    <= '0;
         ptr      <= '0;
         din_q    <= '0;
         start_q  <= 1'b0;
         ack_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         gcnt     <= gcnt_n;
         word_idx <= word_n;
         frame_q  <= frame_n;
         grant_q  <= grant_n;
         goh_q    <= goh_n;
         ptr      <= ptr_n;
         din_q    <= din_n;
         start_q  <= start_n;
         ack_q    <= ack_n;
         done_q   <= uart_done;
      end
   end

   assign busy       = (state != ST_IDLE);
   assign grant_id   = grant_q;
   assign uart_din   = din_q;
   assign uart_start = start_q;
   assign ack        = ack_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with a behavioural uart_tx serializer model
// (no reset, 2 clocks per bit, 1 stop bit, tx_done high during the stop bit)
// and a serial-line decoder collecting received words.
module tb_uart_tx_scheduler;

   localparam int GUARD_CYC = (8 + 1 + 2) << 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [127:0] req_data;
   logic [3:0]   ack;
   logic         busy;
   logic [1:0]   grant_id;
   logic [7:0]   uart_din;
   logic         uart_start;
   logic         uart_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_words[$];
   int         ack_q[$];
   int         exp_acks[$];
   int         gap_q[$];
   logic [31:0] chdata[4];
   int         mptr;
   int         lat;
   int         cyc;

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .N_CH(4), .WORD_WIDTH(8), .FRAME_WORDS(4), .HEADER(1), .SHIFT(1), .STOP_BITS(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .busy       (busy),
      .grant_id   (grant_id),
      .uart_din   (uart_din),
      .uart_start (uart_start),
      .uart_done  (uart_done)
   );

   // ---------------- uart_tx model: 0 idle, 1 start, 2 data, 3 stop
   logic [1:0] u_st    = 2'd0;
   logic       u_cnt   = 1'b0;
   logic [2:0] u_bit   = 3'd0;
   logic [7:0] u_sh    = 8'h00;
   logic       u_valid = 1'b0;
   logic       tx_line;

   assign uart_done = (u_st == 2'd3);

   always_comb begin
      tx_line = 1'b1;
      case (u_st)
         2'd1:    tx_line = 1'b0;
         2'd2:    tx_line = u_sh[u_bit];
         default: tx_line = 1'b1;
      endcase
   end

   always @(posedge clk) begin
      if (!rst_n) u_valid <= 1'b0;
      if (u_st == 2'd0) begin
         if (uart_start) begin
            u_sh    <= uart_din;
            u_st    <= 2'd1;
            u_cnt   <= 1'b0;
            u_valid <= rst_n;
         end
      end else if (u_cnt) begin
         u_cnt <= 1'b0;
         case (u_st)
            2'd1: begin u_st <= 2'd2; u_bit <= 3'd0; end
            2'd2: if (u_bit == 3'd7) u_st <= 2'd3; else u_bit <= u_bit + 3'd1;
            default: begin u_st <= 2'd0; u_valid <= 1'b0; end
         endcase
      end else begin
         u_cnt <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- serial decoder, sampling at the first clock of each bit
   logic [7:0] d_word = 8'h00;
   logic       d_act  = 1'b0;
   int         d_t    = 0;
   int         d_idle = 1000;

   always @(negedge clk) begin
      if (!d_act) begin
         if (tx_line == 1'b0) begin
            d_act <= 1'b1;
            d_t   <= 0;
            if (d_idle < 50) gap_q.push_back(d_idle);
         end else if (d_idle < 1000) begin
            d_idle <= d_idle + 1;
         end
      end else begin
         d_t <= d_t + 1;
         if (d_t >= 1 && d_t <= 15 && (d_t % 2) == 1) d_word[3'((d_t - 1) / 2)] <= tx_line;
         if (d_t == 15) rx_q.push_back({tx_line, d_word[6:0]});
         if (d_t == 18) begin
            d_act  <= 1'b0;
            d_idle <= 0;
         end
      end
   end

   // ---------------- monitors
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) if (ack[c]) ack_q.push_back(c);
      if (ack != 4'b0000) check("ack_onehot", $countones(ack), 1);
   end

   always @(negedge clk) begin
      if (u_valid && (u_st == 2'd1 || u_st == 2'd2))
         check("din_stable", 32'(uart_din), 32'(u_sh));
   end

   int g_cnt = GUARD_CYC;
   always @(negedge clk) begin
      if (!rst_n) g_cnt <= 0;
      else if (g_cnt < GUARD_CYC) begin
         check("guard_no_start", 32'(uart_start), 0);
         check("guard_busy", 32'(busy), 1);
         g_cnt <= g_cnt + 1;
      end
   end

   // ---------------- reference model helpers
   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         int c;
         c = (p + i) % 4;
         if (((r >> c) & 4'b0001) != 4'b0000) return c;
      end
      return 0;
   endfunction

   task automatic set_data();
      req_data = {chdata[3], chdata[2], chdata[1], chdata[0]};
   endtask

   task automatic push_frame(input int g);
      exp_words.push_back(8'hA0 | 8'(g));
      for (int k = 0; k < 4; k++) exp_words.push_back(8'(chdata[g] >> (8 * k)));
      exp_acks.push_back(g);
   endtask

   task automatic wait_acks(input int n, input string tag);
      int got;
      int cy;
      got = 0;
      cy  = 0;
      while (got < n && cy < 200 * n + 100) begin
         @(negedge clk);
         got += $countones(ack);
         cy++;
      end
      req = 4'b0000;
      check({tag, "_ack_in_time"}, 32'(got >= n), 1);
   endtask

   task automatic compare_frames(input string tag);
      check({tag, "_nwords"}, rx_q.size(), exp_words.size());
      for (int i = 0; i < exp_words.size() && i < rx_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), 32'(rx_q[i]), 32'(exp_words[i]));
      check({tag, "_nacks"}, ack_q.size(), exp_acks.size());
      for (int i = 0; i < exp_acks.size() && i < ack_q.size(); i++)
         check($sformatf("%s_ack%0d", tag, i), ack_q[i], exp_acks[i]);
      rx_q.delete();
      exp_words.delete();
      ack_q.delete();
      exp_acks.delete();
   endtask

   task automatic check_gaps(input string tag, input int n_gaps);
      check({tag, "_ngaps"}, gap_q.size(), n_gaps);
      foreach (gap_q[i]) check({tag, "_gap"}, gap_q[i], 1);
      gap_q.delete();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_start"}, 32'(uart_start), 0);
      check({tag, "_din"}, 32'(uart_din), 0);
      check({tag, "_ack"}, 32'(ack), 0);
      check({tag, "_grant_id"}, 32'(grant_id), 0);
      check({tag, "_busy"}, 32'(busy), 1);
   endtask

   task automatic run_frames(input logic [3:0] r, input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         int g;
         g = rr_pick(r, mptr);
         push_frame(g);
         mptr = (g + 1) % 4;
      end
      @(posedge clk); #1;
      req = r;
      wait_acks(n, tag);
      @(negedge clk);
      check({tag, "_busy_low"}, 32'(busy), 0);
      compare_frames(tag);
   endtask

   task automatic randomize_data();
      for (int c = 0; c < 4; c++) chdata[c] = $urandom;
      set_data();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0001;
      for (int c = 1; c < 4; c++) chdata[c] = $urandom;
      chdata[0] = 32'h44332211;
      set_data();
      mptr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");

      // 1: first frame after reset, guard then ch0
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (lat = 0; lat < 200; lat++) begin
         @(negedge clk);
         if (uart_start) break;
      end
      check("t1_grant_latency", lat, GUARD_CYC + 1);
      exp_words.push_back(8'hA0);
      exp_words.push_back(8'h11);
      exp_words.push_back(8'h22);
      exp_words.push_back(8'h33);
      exp_words.push_back(8'h44);
      exp_acks.push_back(0);
      mptr = 1;
      wait_acks(1, "t1");
      @(negedge clk);
      check("t1_busy_low", 32'(busy), 0);
      compare_frames("t1");
      repeat (60) @(posedge clk);

      // 2: two simultaneous requesters, back to back
      randomize_data();
      gap_q.delete();
      run_frames(4'b1010, 2, "t2");
      check_gaps("t2", 9);
      repeat (60) @(posedge clk);

      // 3: all four requesting, pointer wraps
      randomize_data();
      gap_q.delete();
      run_frames(4'b1111, 5, "t3");
      check_gaps("t3", 24);
      repeat (60) @(posedge clk);

      // 4: reset during data word 2
      randomize_data();
      ack_q.delete();
      rx_q.delete();
      @(posedge clk); #1;
      req = 4'b0100;
      cyc = 0;
      while (rx_q.size() < 3 && cyc < 400) begin
         @(posedge clk);
         cyc++;
      end
      check("t4_reached_word1", 32'(rx_q.size() >= 3), 1);
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("t4_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      mptr = 0;
      repeat (GUARD_CYC - 2) @(posedge clk);
      #1;
      rx_q.delete();
      gap_q.delete();
      begin
         int g;
         g = rr_pick(4'b0100, mptr);
         push_frame(g);
         mptr = (g + 1) % 4;
      end
      wait_acks(1, "t4");
      @(negedge clk);
      check("t4_busy_low", 32'(busy), 0);
      compare_frames("t4");
      repeat (60) @(posedge clk);

      // 5: req and data change right after grant
      randomize_data();
      begin
         int g;
         g = rr_pick(4'b0100, mptr);
         push_frame(g);
         mptr = (g + 1) % 4;
      end
      @(posedge clk); #1;
      req = 4'b0100;
      for (cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (busy) break;
      end
      check("t5_granted", 32'(busy), 1);
      check("t5_grant_id", 32'(grant_id), 2);
      @(posedge clk); #1;
      req = 4'b0000;
      chdata[2] = ~chdata[2];
      set_data();
      wait_acks(1, "t5");
      @(negedge clk);
      check("t5_busy_low", 32'(busy), 0);
      compare_frames("t5");

      repeat (10) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
